iomem_periph_bridge: RTL and testbench

Parametrised peripheral bridge between the PicoRV32 `iomem_*` port and the SoC peripherals. It decodes `iomem_addr[31:24]` into three targets:
- a bank of GPIO output/input registers (successor of the single LED register);
- a Wishbone classic master port toward the EFB or other Wishbone slaves;
- an unmapped-page error response.

It adds multi-word GPIO, synchronised inputs, configurable Wishbone widths and an optional ack timeout.

---
 rtl/iomem_periph_bridge.sv | 175 +++++++++++++++++
 tb/tb_iomem_periph_bridge.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/iomem_periph_bridge.sv
// iomem_periph_bridge: decodes PicoRV32 iomem page into GPIO registers,
// a Wishbone classic master, or an unmapped-page error response.
// Optional build macro IOMEM_WB_TIMEOUT_EN adds a Wishbone ack timeout.
module iomem_periph_bridge #(
   parameter int          GPIO_WORDS     = 4,
   parameter int          GPIO_WIDTH     = 8,
   parameter logic [31:0] GPIO_RESET     = 32'h0000_00A5,
   parameter logic [7:0]  GPIO_PAGE      = 8'h01,
   parameter logic [7:0]  WB_PAGE        = 8'h04,
   parameter int          WB_AW          = 8,
   parameter int          WB_DW          = 8,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             iomem_valid,
   output logic                             iomem_ready,
   input  logic [3:0]                       iomem_wstrb,
   input  logic [31:0]                      iomem_addr,
   input  logic [31:0]                      iomem_wdata,
   output logic [31:0]                      iomem_rdata,
   output logic [GPIO_WORDS*GPIO_WIDTH-1:0] gpio_out,
   input  logic [GPIO_WORDS*GPIO_WIDTH-1:0] gpio_in,
   output logic                             wb_cyc_o,
   output logic                             wb_stb_o,
   output logic                             wb_we_o,
   output logic [WB_AW-1:0]                 wb_adr_o,
   output logic [WB_DW-1:0]                 wb_dat_o,
   input  logic [WB_DW-1:0]                 wb_dat_i,
   input  logic                             wb_ack_i,
   output logic                             bus_err
);

   localparam int LOGW = $clog2(GPIO_WORDS);
   localparam int IDXW = (LOGW > 0) ? LOGW : 1;

   typedef enum logic [1:0] {IDLE, WB, RESP} state_t;

   state_t                           state_reg, state_next;
   logic [31:0]                      rdata_reg, rdata_next;
   logic                             err_reg, err_next;
   logic                             wb_load, gpio_wr, tmo_hit;
   logic [GPIO_WIDTH-1:0]            gpio_reg [GPIO_WORDS];
   logic [GPIO_WORDS*GPIO_WIDTH-1:0] gpio_meta_reg, gpio_sync_reg;
   logic [IDXW-1:0]                  word_idx;
   logic                             sel_in;
   logic [GPIO_WIDTH-1:0]            out_word, in_word;
   logic [31:0]                      gpio_rd_val;
   logic                             unused_bits;

   // Word index is masked so a single-word bank always addresses word 0.
   assign word_idx    = IDXW'(iomem_addr[31:2]) & IDXW'(GPIO_WORDS - 1);
   assign sel_in      = iomem_addr[2 + LOGW];
   assign out_word    = gpio_reg[word_idx];
   assign in_word     = gpio_sync_reg[int'(word_idx) * GPIO_WIDTH +: GPIO_WIDTH];
   assign gpio_rd_val = sel_in ? 32'(in_word) : 32'(out_word);
   assign unused_bits = ^{iomem_addr, iomem_wdata};

   assign iomem_ready = (state_reg == RESP);
   assign iomem_rdata = rdata_reg;
   assign bus_err     = err_reg;
   assign wb_cyc_o    = (state_reg == WB);
   assign wb_stb_o    = (state_reg == WB);

   // State register; async reset aborts any in-flight Wishbone cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next-state decode and completion data selection.
   always_comb begin
      state_next = state_reg;
      rdata_next = rdata_reg;
      err_next   = 1'b0;
      wb_load    = 1'b0;
      gpio_wr    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (iomem_valid) begin
               if (iomem_addr[31:24] == GPIO_PAGE) begin
                  state_next = RESP;
                  rdata_next = gpio_rd_val;
                  gpio_wr    = ~sel_in;
               end else if (iomem_addr[31:24] == WB_PAGE) begin
                  state_next = WB;
                  wb_load    = 1'b1;
               end else begin
                  state_next = RESP;
                  rdata_next = 32'h00BA_DADD;
                  err_next   = 1'b1;
               end
            end
         end
         WB: begin
            // Ack takes priority over a simultaneous timeout expiry.
            if (wb_ack_i) begin
               state_next = RESP;
               rdata_next = 32'(wb_dat_i);
            end else if (tmo_hit) begin
               state_next = RESP;
               rdata_next = 32'hDEAD_BEEF;
               err_next   = 1'b1;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Completion data, error flag and Wishbone request fields.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_reg <= '0;
         err_reg   <= 1'b0;
         wb_we_o   <= 1'b0;
         wb_adr_o  <= '0;
         wb_dat_o  <= '0;
      end else begin
         rdata_reg <= rdata_next;
         err_reg   <= err_next;
         if (wb_load) begin
            wb_we_o  <= |iomem_wstrb;
            wb_adr_o <= iomem_addr[WB_AW+1:2];
            wb_dat_o <= iomem_wdata[WB_DW-1:0];
         end
      end
   end

   // GPIO output bank with per-byte-lane writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int w = 0; w < GPIO_WORDS; w++) gpio_reg[w] <= GPIO_RESET[GPIO_WIDTH-1:0];
      end else if (gpio_wr) begin
         for (int b = 0; b < GPIO_WIDTH; b++)
            if (iomem_wstrb[b/8]) gpio_reg[word_idx][b] <= iomem_wdata[b];
      end
   end

   // Two-flop synchroniser for the asynchronous GPIO inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gpio_meta_reg <= '0;
         gpio_sync_reg <= '0;
      end else begin
         gpio_meta_reg <= gpio_in;
         gpio_sync_reg <= gpio_meta_reg;
      end
   end

   generate
      for (genvar gi = 0; gi < GPIO_WORDS; gi++) begin : g_gpio_out
         assign gpio_out[gi*GPIO_WIDTH +: GPIO_WIDTH] = gpio_reg[gi];
      end
   endgenerate

`ifdef IOMEM_WB_TIMEOUT_EN
   logic [15:0] tmo_cnt_reg;

   assign tmo_hit = (tmo_cnt_reg == 16'(TIMEOUT_CYCLES - 1));

   // Counts stb-high cycles without ack; held at zero outside a Wishbone cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   tmo_cnt_reg <= '0;
      else if (state_reg != WB)  tmo_cnt_reg <= '0;
      else if (!wb_ack_i)        tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
   end
`else
   logic unused_tmo;

   assign tmo_hit    = 1'b0;
   assign unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_iomem_periph_bridge.sv
// Self-checking bench for iomem_periph_bridge: table of iomem transactions
// plus hand sequences for input synchronisation, timeout and mid-cycle reset.
module tb_iomem_periph_bridge;
   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        iomem_valid = 1'b0;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb = '0;
   logic [31:0] iomem_addr = '0;
   logic [31:0] iomem_wdata = '0;
   logic [31:0] iomem_rdata;
   logic [31:0] gpio_out;
   logic [31:0] gpio_in = '0;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [7:0]  wb_adr_o, wb_dat_o;
   logic [7:0]  wb_dat_i = '0;
   logic        wb_ack_i = 1'b0;
   logic        bus_err;

   int checks = 0;
   int failures = 0;

   iomem_periph_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
      .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
      .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
      .gpio_out(gpio_out), .gpio_in(gpio_in),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
      .wb_ack_i(wb_ack_i), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic        is_wb;
      int          ack_at;     // stb cycle in which the slave acks (0 = never)
      logic [7:0]  ack_data;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;    // cycles from valid-sampling edge to ready
      int          exp_stb;
      logic [7:0]  exp_adr;
      logic        exp_we;
      logic [7:0]  exp_dat;
      logic [31:0] exp_gpio;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      logic [31:0] gpio;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Drives one iomem request, plays the Wishbone slave, and checks completion.
   task automatic run_access(input vec_t v);
      exp_t e;
      int   n;
      int   stb_cnt;
      bit   done;
      e = '{v.exp_rdata, v.exp_err, v.exp_lat, v.exp_gpio};
      sb.push_back(e);
      iomem_addr  = v.addr;
      iomem_wstrb = v.wstrb;
      iomem_wdata = v.wdata;
      iomem_valid = 1'b1;
      n = 0; stb_cnt = 0; done = 1'b0;
      while (!done && n < 100) begin
         @(posedge clk); #1;
         n++;
         wb_ack_i = 1'b0;
         wb_dat_i = '0;
         if (iomem_ready) begin
            done = 1'b1;
            e = sb.pop_front();
            chk("rdata", iomem_rdata, e.rdata);
            chk("bus_err", 32'(bus_err), 32'(e.err));
            chk("latency", n, e.lat);
            chk("gpio_out", gpio_out, e.gpio);
            if (v.is_wb) chk("stb_cycles", stb_cnt, v.exp_stb);
         end else if (wb_stb_o) begin
            stb_cnt++;
            if (stb_cnt == 1 && v.is_wb) begin
               chk("wb_cyc", 32'(wb_cyc_o), 32'd1);
               chk("wb_adr", 32'(wb_adr_o), 32'(v.exp_adr));
               chk("wb_we", 32'(wb_we_o), 32'(v.exp_we));
               chk("wb_dat_o", 32'(wb_dat_o), 32'(v.exp_dat));
            end
            if (stb_cnt == v.ack_at) begin
               wb_ack_i = 1'b1;
               wb_dat_i = v.ack_data;
            end
         end
      end
      if (!done) begin
         checks++; failures++;
         $display("FAIL ready_timeout actual=no_ready required=ready addr=%h", v.addr);
         void'(sb.pop_front());
      end
      $display("txn addr=%h wstrb=%b rdata=%h err=%b lat=%0d stb=%0d", v.addr, v.wstrb,
               iomem_rdata, bus_err, n, stb_cnt);
      @(posedge clk); #1;
      iomem_valid = 1'b0;
      chk("ready_one_cycle", 32'(iomem_ready), 32'd0);
      chk("err_one_cycle", 32'(bus_err), 32'd0);
      if (done) chk("rdata_hold", iomem_rdata, e.rdata);
   endtask

   initial begin
      vec_t v;
      int   seen;
      //        addr          strb     wdata         wb ack ad     rdata        er lat stb adr    we dat    gpio
      vecs[0]  = '{32'h0100_0000, 4'h0, 32'h0,         0, 0, 8'h00, 32'h0000_00A5, 0, 1, 0, 8'h00, 0, 8'h00, 32'hA5A5_A5A5};
      vecs[1]  = '{32'h0100_000C, 4'h0, 32'h0,         0, 0, 8'h00, 32'h0000_00A5, 0, 1, 0, 8'h00, 0, 8'h00, 32'hA5A5_A5A5};
      vecs[2]  = '{32'h0100_0004, 4'h1, 32'h0000_003C, 0, 0, 8'h00, 32'h0000_00A5, 0, 1, 0, 8'h00, 0, 8'h00, 32'hA5A5_3CA5};
      vecs[3]  = '{32'h0100_0004, 4'h0, 32'h0,         0, 0, 8'h00, 32'h0000_003C, 0, 1, 0, 8'h00, 0, 8'h00, 32'hA5A5_3CA5};
      vecs[4]  = '{32'h0100_0008, 4'h2, 32'h0000_FF00, 0, 0, 8'h00, 32'h0000_00A5, 0, 1, 0, 8'h00, 0, 8'h00, 32'hA5A5_3CA5};
      vecs[5]  = '{32'h0100_0008, 4'h0, 32'h0,         0, 0, 8'h00, 32'h0000_00A5, 0, 1, 0, 8'h00, 0, 8'h00, 32'hA5A5_3CA5};
      vecs[6]  = '{32'h0400_0048, 4'h0, 32'h0,         1, 3, 8'h77, 32'h0000_0077, 0, 4, 3, 8'h12, 0, 8'h00, 32'hA5A5_3CA5};
      vecs[7]  = '{32'h0400_0004, 4'h1, 32'h0000_00AB, 1, 1, 8'h00, 32'h0000_0000, 0, 2, 1, 8'h01, 1, 8'hAB, 32'hA5A5_3CA5};
      vecs[8]  = '{32'h0200_0000, 4'h0, 32'h0,         0, 0, 8'h00, 32'h00BA_DADD, 1, 1, 0, 8'h00, 0, 8'h00, 32'hA5A5_3CA5};
      vecs[9]  = '{32'h0100_0014, 4'hF, 32'h0000_00FF, 0, 0, 8'h00, 32'h0000_0000, 0, 1, 0, 8'h00, 0, 8'h00, 32'hA5A5_3CA5};
      vecs[10] = '{32'h0100_000C, 4'hF, 32'h1234_5699, 0, 0, 8'h00, 32'h0000_00A5, 0, 1, 0, 8'h00, 0, 8'h00, 32'h99A5_3CA5};
      vecs[11] = '{32'h0100_000C, 4'h0, 32'h0,         0, 0, 8'h00, 32'h0000_0099, 0, 1, 0, 8'h00, 0, 8'h00, 32'h99A5_3CA5};
      vecs[12] = '{32'h0400_03FC, 4'h0, 32'h0000_5566, 1, 2, 8'hC4, 32'h0000_00C4, 0, 3, 2, 8'hFF, 0, 8'h66, 32'h99A5_3CA5};
      vecs[13] = '{32'hFF00_0010, 4'hF, 32'hFFFF_FFFF, 0, 0, 8'h00, 32'h00BA_DADD, 1, 1, 0, 8'h00, 0, 8'h00, 32'h99A5_3CA5};
      vecs[14] = '{32'h0100_0000, 4'h3, 32'h0000_1E1E, 0, 0, 8'h00, 32'h0000_00A5, 0, 1, 0, 8'h00, 0, 8'h00, 32'h99A5_3C1E};

      // Reset state
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_ready", 32'(iomem_ready), 32'd0);
      chk("rst_rdata", iomem_rdata, 32'd0);
      chk("rst_bus_err", 32'(bus_err), 32'd0);
      chk("rst_wb", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o}, 32'd0);
      chk("rst_gpio_out", gpio_out, 32'hA5A5_A5A5);
      @(posedge clk); #1;

      foreach (vecs[i]) run_access(vecs[i]);

      // Synchronised inputs readable two edges after they change
      gpio_in = 32'h00C3_005A;
      repeat (2) @(posedge clk);
      #1;
      v = '{32'h0100_0010, 4'h0, 32'h0, 0, 0, 8'h00, 32'h0000_005A, 0, 1, 0, 8'h00, 0, 8'h00, 32'h99A5_3C1E};
      run_access(v);
      v.addr = 32'h0100_0018; v.exp_rdata = 32'h0000_00C3;
      run_access(v);

`ifdef IOMEM_WB_TIMEOUT_EN
      // No ack: timeout after TMO stb cycles
      v = '{32'h0400_0000, 4'h0, 32'h0, 1, 0, 8'h00, 32'hDEAD_BEEF, 1, TMO + 1, TMO, 8'h00, 0, 8'h00, 32'h99A5_3C1E};
      run_access(v);
      // Ack in the expiry cycle wins
      v = '{32'h0400_0000, 4'h0, 32'h0, 1, TMO, 8'h5E, 32'h0000_005E, 0, TMO + 1, TMO, 8'h00, 0, 8'h00, 32'h99A5_3C1E};
      run_access(v);
`endif

      // Reset during a Wishbone wait aborts immediately
      iomem_addr = 32'h0400_0000; iomem_wstrb = 4'h0; iomem_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_stb_before", 32'(wb_stb_o), 32'd1);
      rst = 1'b1;
      #1;
      chk("abort_cyc_stb", {wb_cyc_o, wb_stb_o}, 32'd0);
      chk("abort_gpio_out", gpio_out, 32'hA5A5_A5A5);
      chk("abort_rdata", iomem_rdata, 32'd0);
      iomem_valid = 1'b0;
      seen = 0;
      repeat (2) begin
         @(posedge clk); #1;
         if (iomem_ready) seen++;
      end
      rst = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (iomem_ready) seen++;
      end
      chk("abort_no_ready", seen, 0);
      $display("txn reset_abort ready_seen=%0d gpio_out=%h", seen, gpio_out);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
